// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / divide unit.
//   Multiply: radix-2 shift-add, full 2*WIDTH-bit product on {hi, lo}.
//   Divide:   restoring shift-subtract, quotient on lo, remainder on hi.
//   FSM: IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
//   A divide by zero skips straight from PREP to DONE and raises div_zero.
// Build option: define MULDIV_SIGNED_EN to honour signed_op (two's
// complement operands). Without it every operation is unsigned and the
// sign logic is not built; latency is identical in both builds.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [WIDTH-1:0] qr_q, qr_d;     // multiplier bits / quotient bits
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    // Operand magnitudes presented to the iterative core in PREP.
    logic [WIDTH-1:0] mag_a, mag_b;

    // Sign-corrected results, consumed in FIX.
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_raw = {acc_q, qr_q};

`ifdef MULDIV_SIGNED_EN
    logic sgn_q, sgn_d;
    logic neg_q, neg_d;     // product / quotient is negative
    logic rneg_q, rneg_d;   // remainder is negative (follows dividend)
    logic a_neg, b_neg;

    assign a_neg    = sgn_q & a_q[WIDTH-1];
    assign b_neg    = sgn_q & b_q[WIDTH-1];
    assign mag_a    = a_neg ? -a_q : a_q;
    assign mag_b    = b_neg ? -b_q : b_q;
    assign prod_fix = neg_q  ? -prod_raw : prod_raw;
    assign quo_fix  = neg_q  ? -qr_q     : qr_q;
    assign rem_fix  = rneg_q ? -acc_q    : acc_q;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign mag_a    = a_q;
    assign mag_b    = b_q;
    assign prod_fix = prod_raw;
    assign quo_fix  = qr_q;
    assign rem_fix  = acc_q;
`endif

    // One multiply iteration: conditionally add, then shift {acc, qr} right.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, acc_q} + {1'b0, (qr_q[0] ? opb_q : '0)};

    // One restoring divide iteration: shift in next dividend bit, trial subtract.
    logic [WIDTH:0]   div_shift, div_diff;
    assign div_shift = {acc_q, qr_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    // Next-state and datapath update for every register in the unit.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
`ifdef MULDIV_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    dz_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
                    sgn_d   = signed_op;
`endif
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                if (op_q && (b_q == '0)) begin
                    // Divide by zero: flag it, leave hi/lo untouched.
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d   = '0;
                    qr_d    = mag_a;
                    opb_d   = mag_b;
                    cnt_d   = CNT_INIT;
`ifdef MULDIV_SIGNED_EN
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
`endif
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                if (op_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    qr_d  = {mul_sum[0], qr_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset clears control, operands and results alike.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy     = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue. The stimulus
// process pushes the expected {hi, lo, div_zero, done cycle} per accepted
// operation; a monitor pops and compares on every done pulse.
// Expected values follow MULDIV_SIGNED_EN when it is defined.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           dcyc;
        string        name;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                check({e.name, "_div_zero"}, div_zero, e.dz);
                check({e.name, "_latency"}, cyc, e.dcyc);
            end
        end
    end

    // Issue one operation; lat = edges from E0 to the edge that raises done.
    // With spam set, start stays high through busy and the DONE edge.
    task automatic do_op(input logic o, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input int lat, input string nm, input bit spam);
        exp_t e;
        @(negedge clk);
        op = o; signed_op = s; a = av; b = bv; start = 1'b1;
        e.hi = eh; e.lo = el; e.dz = ed; e.dcyc = cyc + 1 + lat; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = ~o; signed_op = ~s;
        if (!spam) start = 1'b0;
        for (int i = 0; i < 80 && done !== 1'b1; i++) @(negedge clk);
        check({nm, "_done_seen"}, done, 1);
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy_after"}, busy, 0);
        check({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ph, pl;

        // Reset values while reset is held.
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // First edge after reset accepts start.
        do_op(1'b0, 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 34, "mul_7x6", 1'b0);
`ifdef MULDIV_SIGNED_EN
        do_op(1'b0, 1'b1, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, "mul_s_m3x5", 1'b0);
        do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 34, "mul_s_m1xm1", 1'b0);
`else
        do_op(1'b0, 1'b1, -32'sd3, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 34, "mul_u_m3x5", 1'b0);
        do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34, "mul_u_max", 1'b0);
`endif
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34, "mul_max", 1'b0);
        do_op(1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, "div_100_7", 1'b0);
`ifdef MULDIV_SIGNED_EN
        ph = 32'hFFFF_FFFF; pl = 32'hFFFF_FFFD;
`else
        ph = 32'h1; pl = 32'h7FFF_FFFC;
`endif
        do_op(1'b1, 1'b1, -32'sd7, 32'd2, ph, pl, 1'b0, 34, "div_m7_2", 1'b0);

        // Divide by zero: early done, flag set, results held.
        do_op(1'b1, 1'b0, 32'd5, 32'd0, ph, pl, 1'b1, 1, "div_by_0", 1'b0);

        // Next accepted start clears div_zero; most-negative / -1.
`ifdef MULDIV_SIGNED_EN
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, "div_min_m1", 1'b0);
`else
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 34, "div_min_m1", 1'b0);
`endif

        // Start held high during busy and DONE is ignored.
        do_op(1'b0, 1'b0, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0, 34, "mul_spam", 1'b1);
        repeat (3) @(negedge clk);
        check("spam_no_restart", busy, 0);

        // Reset mid-CALC clears everything before the next edge.
        @(negedge clk);
        op = 1'b0; signed_op = 1'b0; a = 32'd7; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_calc_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_div_zero", div_zero, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        do_op(1'b0, 1'b0, 32'd12, 32'd12, 32'h0, 32'd144, 1'b0, 34, "mul_after_rst", 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
